// File: rtl/float_to_int_seq.sv
// float_to_int_seq: 13-bit {sign, exp, 0.frac} float to 8-bit signed integer.
// One right-shift per cycle, truncating, with saturation and inexact flag.
module float_to_int_seq #(
    parameter int FRAC_W = 8,
    parameter int EXP_W  = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+FRAC_W:0]   float_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [FRAC_W-1:0]       int_out,
    output logic                    overflow,
    output logic                    inexact
);

    localparam int CNT_W = $clog2(FRAC_W + 1);

    localparam logic [FRAC_W-1:0] SAT_POS = {1'b0, {(FRAC_W-1){1'b1}}};
    localparam logic [FRAC_W-1:0] SAT_NEG = {1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic [FRAC_W:0]   POS_LIM = {2'b00, {(FRAC_W-1){1'b1}}};
    localparam logic [FRAC_W:0]   NEG_LIM = {2'b01, {(FRAC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                sign_q, sign_d;
    logic [FRAC_W:0]     mag_q, mag_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sticky_q, sticky_d;
    logic                ovf_pre_q, ovf_pre_d;
    logic                valid_q, valid_d;
    logic [FRAC_W-1:0]   int_q, int_d;
    logic                ovf_q, ovf_d;
    logic                inex_q, inex_d;

    logic                f_sign;
    logic [EXP_W-1:0]    f_exp;
    logic [FRAC_W-1:0]   f_frac;
    logic [31:0]         e_ext;
    logic [FRAC_W:0]     neg_mag;

    assign f_sign  = float_in[EXP_W+FRAC_W];
    assign f_exp   = float_in[FRAC_W +: EXP_W];
    assign f_frac  = float_in[FRAC_W-1:0];
    assign e_ext   = 32'(f_exp);
    assign neg_mag = -mag_q;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = valid_q;
    assign int_out   = int_q;
    assign overflow  = ovf_q;
    assign inexact   = inex_q;

    // Next-state and datapath: accept, shift one bit per cycle, then saturate.
    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        mag_d     = mag_q;
        cnt_d     = cnt_q;
        sticky_d  = sticky_q;
        ovf_pre_d = ovf_pre_q;
        valid_d   = valid_q;
        int_d     = int_q;
        ovf_d     = ovf_q;
        inex_d    = inex_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d   = f_sign;
                    mag_d    = {1'b0, f_frac};
                    sticky_d = 1'b0;
                    if (e_ext > 32'(FRAC_W)) begin
                        cnt_d     = '0;
                        ovf_pre_d = 1'b1;
                    end else begin
                        cnt_d     = CNT_W'(32'(FRAC_W) - e_ext);
                        ovf_pre_d = 1'b0;
                    end
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    mag_d    = mag_q >> 1;
                    sticky_d = sticky_q | mag_q[0];
                    cnt_d    = cnt_q - CNT_W'(1);
                end else begin
                    valid_d = 1'b1;
                    state_d = DONE;
                    if (ovf_pre_q) begin
                        int_d  = sign_q ? SAT_NEG : SAT_POS;
                        ovf_d  = 1'b1;
                        inex_d = 1'b0;
                    end else if (!sign_q && mag_q > POS_LIM) begin
                        int_d  = SAT_POS;
                        ovf_d  = 1'b1;
                        inex_d = 1'b0;
                    end else if (sign_q && mag_q > NEG_LIM) begin
                        int_d  = SAT_NEG;
                        ovf_d  = 1'b1;
                        inex_d = 1'b0;
                    end else begin
                        int_d  = sign_q ? neg_mag[FRAC_W-1:0]
                                        : mag_q[FRAC_W-1:0];
                        ovf_d  = 1'b0;
                        inex_d = sticky_q;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any word in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sign_q    <= 1'b0;
            mag_q     <= '0;
            cnt_q     <= '0;
            sticky_q  <= 1'b0;
            ovf_pre_q <= 1'b0;
            valid_q   <= 1'b0;
            int_q     <= '0;
            ovf_q     <= 1'b0;
            inex_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            mag_q     <= mag_d;
            cnt_q     <= cnt_d;
            sticky_q  <= sticky_d;
            ovf_pre_q <= ovf_pre_d;
            valid_q   <= valid_d;
            int_q     <= int_d;
            ovf_q     <= ovf_d;
            inex_q    <= inex_d;
        end
    end

endmodule

// File: tb/tb_float_to_int_seq.sv
// tb_float_to_int_seq: randomized and directed checks of float_to_int_seq
// against an arithmetic model of value = (-1)^s * frac/256 * 2^e.
module tb_float_to_int_seq;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] float_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  int_out;
    logic        overflow;
    logic        inexact;

    float_to_int_seq dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .float_in (float_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .int_out  (int_out),
        .overflow (overflow),
        .inexact  (inexact)
    );

    typedef struct {
        logic [7:0] v;
        bit         ovf;
        bit         inx;
        int         lat;
        int         acc;
    } exp_t;

    int   nchk = 0;
    int   nerr = 0;
    int   cyc  = 0;
    bit   chk_en = 0;
    bit   rdy_force = 1;
    bit   have_job = 0;
    bit   busy;
    bit   ov_exp;
    exp_t job;
    exp_t q[$];
    exp_t m;

    logic [12:0] dir [8] = '{
        13'b0_0101_11001000,
        13'b1_0101_11001000,
        13'b1_1000_10000000,
        13'b0_1000_10000000,
        13'b0_1001_11111111,
        13'b0_0000_11111111,
        13'b0_0011_10110000,
        13'b1_0011_00000000
    };

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     n, act, exp, cyc);
        end
    endtask

    // Truncated signed value of the float, saturated to 8 bits.
    function automatic exp_t model(input logic [12:0] w);
        exp_t r;
        int   e;
        int   f;
        int   scaled;
        int   mag;
        int   val;
        e = int'(w[11:8]);
        f = int'(w[7:0]);
        r.acc = 0;
        if (e > 8) begin
            r.v   = w[12] ? 8'h80 : 8'h7f;
            r.ovf = 1;
            r.inx = 0;
            r.lat = 1;
        end else begin
            scaled = f * (1 << e);
            mag    = scaled / 256;
            val    = w[12] ? -mag : mag;
            r.lat  = 9 - e;
            if (val > 127) begin
                r.v = 8'h7f; r.ovf = 1; r.inx = 0;
            end else if (val < -128) begin
                r.v = 8'h80; r.ovf = 1; r.inx = 0;
            end else begin
                r.v   = 8'(val);
                r.ovf = 0;
                r.inx = (scaled % 256) != 0;
            end
        end
        return r;
    endfunction

    // Random consumer backpressure, changed away from the sampling edge.
    always @(posedge clk) begin
        #1;
        if (!rdy_force) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Every-cycle comparison of handshake and result against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            if (!have_job && q.size() > 0) begin
                job = q.pop_front();
                have_job = 1;
            end
            busy   = have_job && (cyc >= job.acc);
            ov_exp = have_job && (cyc >= job.acc + job.lat);
            chk("in_ready", 32'(in_ready), 32'(!busy));
            chk("out_valid", 32'(out_valid), 32'(ov_exp));
            if (ov_exp && out_valid) begin
                chk("int_out", 32'(int_out), 32'(job.v));
                chk("overflow", 32'(overflow), 32'(job.ovf));
                chk("inexact", 32'(inexact), 32'(job.inx));
                if (out_ready) have_job = 0;
            end
        end
    end

    task automatic send(input logic [12:0] w);
        exp_t e;
        int   n;
        @(negedge clk);
        in_valid = 1;
        float_in = w;
        for (n = 0; !in_ready && n < 60; n++) @(negedge clk);
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            e = model(w);
            e.acc = cyc + 1;
            q.push_back(e);
            @(posedge clk);
        end
        #1 in_valid = 0;
    endtask

    task automatic drain();
        int n;
        for (n = 0; (have_job || q.size() > 0) && n < 100; n++)
            @(negedge clk);
        chk("drain_timeout", 32'(have_job), 32'd0);
    endtask

    initial begin
        reset_n   = 0;
        in_valid  = 0;
        float_in  = '0;
        out_ready = 1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_int_out", 32'(int_out), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_inexact", 32'(inexact), 32'd0);

        m = model(13'b0_0101_11001000);
        chk("pin_p25", 32'(m.v), 32'd25);
        chk("pin_p25_lat", 32'(m.lat), 32'd4);
        m = model(13'b1_0101_11001000);
        chk("pin_m25", 32'(m.v), 32'(8'hE7));
        m = model(13'b1_1000_10000000);
        chk("pin_m128", 32'({m.v, m.ovf}), 32'({8'h80, 1'b0}));
        m = model(13'b0_1000_10000000);
        chk("pin_sat", 32'({m.v, m.ovf}), 32'({8'h7f, 1'b1}));
        m = model(13'b0_0011_10110000);
        chk("pin_trunc5", 32'({m.v, m.inx}), 32'({8'd5, 1'b1}));
        m = model(13'b0_0000_11111111);
        chk("pin_lat9", 32'({m.v, m.inx, 4'(m.lat)}),
            32'({8'd0, 1'b1, 4'd9}));

        repeat (2) @(negedge clk);
        #2 reset_n = 1;
        chk_en = 1;

        foreach (dir[i]) send(dir[i]);
        drain();

        out_ready = 0;
        send(13'b0_0110_10101010);
        for (int n = 0; !out_valid && n < 20; n++) @(negedge clk);
        chk("bp_valid", 32'(out_valid), 32'd1);
        in_valid = 1;
        float_in = 13'b1_0100_11110001;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1;
        send(13'b1_0100_11110001);
        drain();

        rdy_force = 0;
        for (int i = 0; i < 300; i++) begin
            logic [12:0] w;
            w = 13'($urandom);
            w[11:8] = 4'($urandom_range(0, 10));
            if ($urandom_range(0, 9) == 0) w[7:0] = '0;
            send(w);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        rdy_force = 1;
        out_ready = 1;
        send(13'b0_0000_11111111);
        repeat (3) @(negedge clk);
        #3;
        chk_en   = 0;
        reset_n  = 0;
        #1;
        chk("mid_in_ready", 32'(in_ready), 32'd1);
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_int_out", 32'(int_out), 32'd0);
        q.delete();
        have_job = 0;
        @(negedge clk);
        #2 reset_n = 1;
        chk_en = 1;
        repeat (15) @(negedge clk);

        send(13'b0_0111_01100100);
        drain();
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/float_to_int_seq.md
Name: float_to_int_seq

Overview:
Sequential converter from the team's 13-bit floating-point format back to an 8-bit signed integer. It is the downstream neighbour of the int-to-float converter and consumes its output word. The 13-bit word is sign[12], exponent[11:8] (unsigned), and significand[7:0] as fraction 0.f, so value = (-1)^s * 0.f * 2^e. Conversion uses a one-bit-per-cycle right shifter behind valid/ready handshakes on both sides, with saturation and an inexact flag.

Parameters:
FRAC_W, 8, significand width; also the integer width and the shift reference point.
EXP_W, 4, exponent width (unsigned).

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  float_in is valid
in_ready  output  1  block can accept a word
float_in  input  1+EXP_W+FRAC_W (13)  {sign, exp, frac}
out_valid  output  1  int_out and flags are valid
out_ready  input  1  consumer accepts the result
int_out  output  FRAC_W (8)  signed two's-complement result
overflow  output  1  result was saturated
inexact  output  1  nonzero bits were truncated

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; in_ready=1; out_valid=0; int_out=0; overflow=0; inexact=0; internal mag, cnt, and sticky cleared. Reset mid-conversion abandons the word and emits no output.
- States: IDLE, SHIFT, DONE. in_ready = (state==IDLE), combinational from state.
- IDLE: when in_valid and in_ready are high at an edge, latch sign, mag={1'b0,frac} (9 bits), and sticky=0.
  - If e > FRAC_W: set cnt=0 and an ovf_pre flag.
  - Otherwise: set cnt=FRAC_W-e and ovf_pre=0.
  - Go to SHIFT.
- SHIFT: each edge with cnt>0 does mag <= mag>>1, sticky <= sticky | mag[0], cnt <= cnt-1.
  - On the edge where cnt==0, register the result, set out_valid=1, and go to DONE.
- Result rules:
  - If ovf_pre: int_out=sign ? -128 : +127, overflow=1.
  - If sign=0 and mag>127: int_out=+127, overflow=1.
  - If sign=1 and mag>128: int_out=-128, overflow=1. mag==128 gives -128 exactly, with no overflow.
  - Otherwise int_out = sign ? -mag : mag, overflow=0.
  - inexact = sticky, and is 0 when overflow=1.
  - Rounding is truncation toward zero on the magnitude.
  - frac=0 yields int_out=0 with no flags for any exponent ≤ FRAC_W. sign=1 with frac=0 yields 0, never -0.
- Latency: out_valid rises k+1 edges after the accept edge, where k=cnt. Maximum is 9 edges (e=0); minimum is 1 edge (e≥8).
- DONE: int_out, overflow, and inexact are held stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1: out_valid <= 0 and state goes to IDLE. Outputs keep their last value.
  - A new word is accepted no earlier than the edge after the return to IDLE, so sustained throughput is one word per k+3 cycles.
- in_valid while busy is ignored, and the producer must hold the word. Malformed (unnormalized) significands are converted arithmetically, with no error.

Test Plan:
- Reset: drive reset_n=0 mid-SHIFT of any word -> outputs immediately read in_ready=1, out_valid=0, int_out=0, and no result is emitted after release.
- Accept 13'b0_0101_11001000 (+25), out_ready=1 -> out_valid rises 4 edges after accept with int_out=25, overflow=0, inexact=0. Then 13'b1_0101_11001000 -> int_out=-25.
- Boundaries:
  - 13'b1_1000_10000000 -> int_out=-128, no flags, latency 1.
  - 13'b0_1000_10000000 -> int_out=127, overflow=1.
  - 13'b0_1001_11111111 (e=9) -> int_out=127, overflow=1.
- Truncation: 13'b0_0000_11111111 -> int_out=0, inexact=1, latency 9 edges. 13'b0_0011_10110000 -> int_out=5, inexact=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> int_out and flags stable, in_ready=0, and a presented in_valid is ignored. Releasing out_ready returns to IDLE, and the next word converts correctly.
- Zero: 13'b1_0011_00000000 -> int_out=0, overflow=0, inexact=0.
